// File: rtl/stream_min_max_if.sv
// Sample-stream and frame-result handshake bundle for stream_min_max.
// out_min_idx exists only when STREAM_MM_IDX_EN is defined.
interface stream_min_max_if #(
  parameter int DATA_W = 8,
  parameter int IDX_W  = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_min;
  logic [DATA_W-1:0] out_max;
`ifdef STREAM_MM_IDX_EN
  logic [IDX_W-1:0]  out_min_idx;
`endif
  logic [IDX_W-1:0]  out_len;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_min, out_max,
`ifdef STREAM_MM_IDX_EN
    input  out_min_idx,
`endif
    input  out_len
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_min, out_max,
`ifdef STREAM_MM_IDX_EN
    output out_min_idx,
`endif
    output out_len
  );
endinterface

// File: rtl/stream_min_max.sv
// Per-frame running min/max/length reduction over a valid/ready sample stream.
// Define STREAM_MM_IDX_EN to add argmin (first occurrence) tracking.
module stream_min_max #(
  parameter int DATA_W = 8,
  parameter int IDX_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  stream_min_max_if.slave  s
);
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_e;

  localparam logic [IDX_W-1:0] LEN_MAX = '1;

  state_e            state_q, state_d;
  logic              beat;
  logic [DATA_W-1:0] acc_min_q, acc_min_d, acc_max_q, acc_max_d;
  logic [DATA_W-1:0] res_min_q, res_max_q;
  logic [IDX_W-1:0]  acc_len_q, acc_len_d, res_len_q;
`ifdef STREAM_MM_IDX_EN
  logic [IDX_W-1:0]  acc_idx_q, acc_idx_d, res_idx_q;
`endif

  assign beat = s.in_valid & s.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (beat) state_d = s.in_last ? HOLD : ACCUM;
      ACCUM:   if (beat && s.in_last) state_d = HOLD;
      HOLD:    if (s.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s.in_ready  = (state_q != HOLD);
    s.out_valid = (state_q == HOLD);
  end

  // len doubles as the index of the incoming beat, so it also feeds argmin.
  always_comb begin
    acc_min_d = acc_min_q;
    acc_max_d = acc_max_q;
    acc_len_d = acc_len_q;
`ifdef STREAM_MM_IDX_EN
    acc_idx_d = acc_idx_q;
`endif
    if (beat) begin
      if (state_q == IDLE) begin
        acc_min_d = s.in_data;
        acc_max_d = s.in_data;
        acc_len_d = IDX_W'(1);
`ifdef STREAM_MM_IDX_EN
        acc_idx_d = '0;
`endif
      end else begin
        if (s.in_data < acc_min_q) begin
          acc_min_d = s.in_data;
`ifdef STREAM_MM_IDX_EN
          acc_idx_d = acc_len_q;
`endif
        end
        if (s.in_data > acc_max_q) acc_max_d = s.in_data;
        if (acc_len_q != LEN_MAX) acc_len_d = acc_len_q + IDX_W'(1);
      end
    end
  end

  // Result registers load only on the closing beat so outputs survive the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_min_q <= '0;
      acc_max_q <= '0;
      acc_len_q <= '0;
      res_min_q <= '0;
      res_max_q <= '0;
      res_len_q <= '0;
`ifdef STREAM_MM_IDX_EN
      acc_idx_q <= '0;
      res_idx_q <= '0;
`endif
    end else begin
      acc_min_q <= acc_min_d;
      acc_max_q <= acc_max_d;
      acc_len_q <= acc_len_d;
`ifdef STREAM_MM_IDX_EN
      acc_idx_q <= acc_idx_d;
`endif
      if (beat && s.in_last) begin
        res_min_q <= acc_min_d;
        res_max_q <= acc_max_d;
        res_len_q <= acc_len_d;
`ifdef STREAM_MM_IDX_EN
        res_idx_q <= acc_idx_d;
`endif
      end
    end
  end

  assign s.out_min = res_min_q;
  assign s.out_max = res_max_q;
  assign s.out_len = res_len_q;
`ifdef STREAM_MM_IDX_EN
  assign s.out_min_idx = res_idx_q;
`endif
endmodule

// File: tb/tb_stream_min_max.sv
// Randomized frame bench for stream_min_max: an 8-bit-index instance and a
// 2-bit-index instance (saturation) checked against a queue-based frame model.
module tb_stream_min_max;
  typedef logic [7:0] smp_q_t[$];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stream_min_max_if #(.DATA_W(8), .IDX_W(8)) ia ();
  stream_min_max_if #(.DATA_W(8), .IDX_W(2)) ib ();

  stream_min_max #(.DATA_W(8), .IDX_W(8)) u_a (.clk(clk), .rst_n(rst_n), .s(ia.slave));
  stream_min_max #(.DATA_W(8), .IDX_W(2)) u_b (.clk(clk), .rst_n(rst_n), .s(ib.slave));

  int         sel = 0;
  logic       drv_valid = 1'b0, drv_last = 1'b0, drv_ordy = 1'b0;
  logic [7:0] drv_data = '0;

  assign ia.in_valid  = (sel == 0) & drv_valid;
  assign ia.in_data   = drv_data;
  assign ia.in_last   = drv_last;
  assign ia.out_ready = (sel == 0) & drv_ordy;
  assign ib.in_valid  = (sel == 1) & drv_valid;
  assign ib.in_data   = drv_data;
  assign ib.in_last   = drv_last;
  assign ib.out_ready = (sel == 1) & drv_ordy;

  logic       obs_in_ready, obs_out_valid;
  logic [7:0] obs_min, obs_max, obs_len;
  assign obs_in_ready  = sel ? ib.in_ready  : ia.in_ready;
  assign obs_out_valid = sel ? ib.out_valid : ia.out_valid;
  assign obs_min       = sel ? ib.out_min   : ia.out_min;
  assign obs_max       = sel ? ib.out_max   : ia.out_max;
  assign obs_len       = sel ? 8'(ib.out_len) : ia.out_len;
`ifdef STREAM_MM_IDX_EN
  logic [7:0] obs_idx;
  assign obs_idx = sel ? 8'(ib.out_min_idx) : ia.out_min_idx;
`endif

  int n_chk = 0, n_fail = 0;
  int e_min, e_max, e_idx, e_len;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Frame reduction from first principles: scan the whole frame, then clip.
  task automatic model(input smp_q_t smp, input int lmax);
    int mn, mx, at;
    mn = smp[0]; mx = smp[0]; at = 0;
    foreach (smp[i]) begin
      if (int'(smp[i]) < mn) begin mn = smp[i]; at = i; end
      if (int'(smp[i]) > mx) mx = smp[i];
    end
    e_min = mn;
    e_max = mx;
    e_idx = (at > lmax) ? lmax : at;
    e_len = (smp.size() > lmax) ? lmax : smp.size();
  endtask

  task automatic chk_result(input string tag);
    chk({tag, ".min"}, obs_min, e_min);
    chk({tag, ".max"}, obs_max, e_max);
    chk({tag, ".len"}, obs_len, e_len);
`ifdef STREAM_MM_IDX_EN
    chk({tag, ".idx"}, obs_idx, e_idx);
`endif
  endtask

  task automatic run_frame(input int s, input smp_q_t smp, input int bub, input int stall);
    sel = s;
    foreach (smp[i]) begin
      while ($urandom_range(99) < bub) begin
        drv_valid = 1'b0;
        drv_data  = 8'($urandom);
        drv_last  = 1'($urandom);
        drv_ordy  = 1'($urandom);
        tick();
      end
      drv_valid = 1'b1;
      drv_data  = smp[i];
      drv_last  = (i == smp.size() - 1);
      drv_ordy  = drv_last ? (stall == 0) : 1'($urandom);
      if (i == 0 || $urandom_range(7) == 0) chk("in_ready_open", obs_in_ready, 1);
      tick();
    end
    model(smp, s ? 3 : 255);
    chk("out_valid_lat1", obs_out_valid, 1);
    chk("in_ready_hold", obs_in_ready, 0);
    chk_result("res");
    // Keep offering junk while the result is pending; none of it may be taken.
    drv_data = 8'($urandom);
    drv_last = 1'b1;
    for (int c = 0; c < stall; c++) begin
      tick();
      chk("out_valid_stall", obs_out_valid, 1);
      chk("in_ready_stall", obs_in_ready, 0);
      chk_result("stall");
    end
    drv_valid = 1'b0;
    drv_ordy  = 1'b1;
    tick();
    drv_ordy  = 1'b0;
    chk("out_valid_drop", obs_out_valid, 0);
    chk("in_ready_reopen", obs_in_ready, 1);
    chk_result("retain");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    smp_q_t q;
    #2;
    chk("rst.out_valid", ia.out_valid, 0);
    chk("rst.in_ready", ia.in_ready, 1);
    chk("rst.min", ia.out_min, 0);
    chk("rst.max", ia.out_max, 0);
    chk("rst.len", ia.out_len, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    q = {8'd5, 8'd3, 8'd9, 8'd3, 8'd7};
    run_frame(0, q, 0, 0);
    q = {8'h80};
    run_frame(0, q, 0, 0);
    q = {8'd10, 8'd20, 8'd0};
    run_frame(0, q, 0, 4);
    q = {8'd4, 8'd6, 8'd2};
    run_frame(0, q, 50, 0);

    // Reset in the middle of a frame discards it and clears the last result.
    sel = 0;
    for (int i = 0; i < 3; i++) begin
      drv_valid = 1'b1; drv_data = 8'(50 + i); drv_last = 1'b0;
      tick();
    end
    drv_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("mid_rst.out_valid", ia.out_valid, 0);
    chk("mid_rst.in_ready", ia.in_ready, 1);
    chk("mid_rst.min", ia.out_min, 0);
    chk("mid_rst.max", ia.out_max, 0);
    chk("mid_rst.len", ia.out_len, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    q = {8'd1, 8'd2};
    run_frame(0, q, 0, 0);

    q = {8'd9, 8'd8, 8'd7, 8'd6, 8'd5};
    run_frame(1, q, 0, 0);

    // Long frame on the wide instance to reach 255-beat saturation.
    q = {};
    for (int i = 0; i < 300; i++) q.push_back(8'($urandom_range(20, 255)));
    q[280] = 8'd3;
    run_frame(0, q, 10, 1);

    for (int f = 0; f < 24; f++) begin
      int n;
      n = $urandom_range(1, 12);
      q = {};
      for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 15)));
      run_frame(f % 2, q, 30, $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
